addsub_seq_ctrl: RTL
====================

// Module: addsub_seq_ctrl
// PURPOSE
//  Multi-word add/subtract sequencer. Takes NWORDS*WORD_W-bit operands in one handshake.
//  Runs them through a single shared WORD_W-bit carry-lookahead adder, one word per cycle, LSW first.
//  Chains the carry through a register and returns the full result, carry and signed overflow.
//  Sits between the ALU issue logic and the wide-arithmetic datapath.
// PARAMETERS
//  WORD_W  32  width of the shared adder slice, bits (>=2)
//  NWORDS  4   words per operand (>=1); operand width OPW = WORD_W*NWORDS
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous reset, active low
//  start_valid  in   1         operands/opcode valid
//  start_ready  out  1         block accepts a new operation
//  op_sub       in   1         0: a+b, 1: a-b
//  a_in         in   OPW       operand A
//  b_in         in   OPW       operand B
//  res          out  OPW       result
//  cout         out  1         add: carry out; sub: 1 = no borrow
//  ovf          out  1         signed overflow of the full OPW-bit operation
//  res_valid    out  1         res/cout/ovf valid
//  res_ready    in   1         consumer takes result
//  busy         out  1         state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; idx=0; carry=0; res=0; cout=0; ovf=0; res_valid=0; busy=0.
//   - start_ready=1 once rst_n is released.
//   - Reset mid-operation aborts immediately; the partial result is discarded.
//  FSM IDLE -> RUN -> DONE -> IDLE. Outputs are registered except start_ready.
//  IDLE:
//   - start_ready=1 combinationally.
//   - On start_valid&start_ready: latch a_in, b_in and op_sub; carry<=op_sub; idx<=0; go to RUN.
//  RUN:
//   - Each cycle: {c,s} = a[idx] + (b[idx] ^ {WORD_W{sub}}) + carry.
//   - res[idx*WORD_W +: WORD_W] <= s; carry <= c; idx <= idx+1.
//   - On idx==NWORDS-1 the same edge sets cout<=c and ovf<=c_msb_in ^ c, then goes to DONE.
//     c_msb_in is the carry into bit OPW-1.
//  DONE:
//   - res_valid=1; res, cout and ovf are held stable.
//   - On res_ready=1: res_valid<=0 and go to IDLE.
//  Latency:
//   - res_valid rises NWORDS cycles after the accepting edge.
//   - The next accept is possible no earlier than the cycle after the result handshake.
//   - Throughput is one operation per NWORDS+2 cycles.
//  Boundary conditions:
//   - start_valid is ignored outside IDLE; its inputs need not be held after acceptance.
//   - res_ready outside DONE has no effect.
//   - Backpressure (res_ready=0) holds DONE indefinitely.
//   - res shows partial words during RUN; it is only meaningful while res_valid=1.
//   - idx wraps only via reset to 0 on acceptance; it is never used beyond NWORDS-1.
//   - NWORDS=1: single RUN cycle; ovf uses the slice MSB carries.
//   - Arithmetic is modulo 2^OPW; sub uses the two's complement ~b + 1 via the initial carry.
// CONFIGURATION
//  ADDSEQ_ZERO_FLAG_EN:
//   - Defined: adds output port zero (1 bit), reset 0, registered with res.
//   - zero=1 in DONE iff res==0.
//   - Accumulated per word during RUN; no extra latency.
//  Undefined: port absent; all other behaviour identical.
// TESTING
//  1 NWORDS=4: a=2^128-1, b=1, add -> res=0, cout=1, ovf=0, res_valid 4 cycles after accept.
//  2 a=0, b=1, sub -> res=2^128-1, cout=0, ovf=0; then a=5, b=3, sub -> res=2, cout=1.
//  3 a=0x7FFF..FF, b=1, add -> res=0x8000..00, ovf=1; a=0x8000..00, b=1, sub -> ovf=1.
//  4 Hold res_ready=0 for 6 cycles in DONE -> res/cout/ovf stable, start_ready=0;
//    start_valid pulses are ignored.
//  5 Drop rst_n in the 2nd RUN cycle -> all outputs 0 immediately; after release start_ready=1;
//    a fresh op (3+4) returns 7.
//  6 NWORDS=1, WORD_W=8: 0x80-0x01 -> res=0x7F, ovf=1, cout=1;
//    with ADDSEQ_ZERO_FLAG_EN, 0x10-0x10 -> zero=1.

Source files
------------

// File: rtl/addsub_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seq_ctrl_if
// Brief    : Issue/result bundle between ALU issue logic and addsub_seq_ctrl.
//            Carries the optional zero flag when ADDSEQ_ZERO_FLAG_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface addsub_seq_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 4
);
    localparam int OPW = WORD_W * NWORDS;

    logic           start_valid;
    logic           start_ready;
    logic           op_sub;
    logic [OPW-1:0] a_in;
    logic [OPW-1:0] b_in;
    logic [OPW-1:0] res;
    logic           cout;
    logic           ovf;
    logic           res_valid;
    logic           res_ready;
    logic           busy;
`ifdef ADDSEQ_ZERO_FLAG_EN
    logic           zero;

    modport master (
        output start_valid, op_sub, a_in, b_in, res_ready,
        input  start_ready, res, cout, ovf, res_valid, busy, zero
    );
    modport slave (
        input  start_valid, op_sub, a_in, b_in, res_ready,
        output start_ready, res, cout, ovf, res_valid, busy, zero
    );
`else
    modport master (
        output start_valid, op_sub, a_in, b_in, res_ready,
        input  start_ready, res, cout, ovf, res_valid, busy
    );
    modport slave (
        input  start_valid, op_sub, a_in, b_in, res_ready,
        output start_ready, res, cout, ovf, res_valid, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seq_ctrl
// Brief    : Multi-word add/subtract sequencer, one WORD_W slice per cycle LSW
//            first through a shared carry-lookahead adder. Optional zero flag
//            output enabled by defining ADDSEQ_ZERO_FLAG_EN.
// Revision : 1.0  initial release
// ============================================================================
module addsub_seq_ctrl #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    addsub_seq_ctrl_if.slave bus
);
    localparam int OPW  = WORD_W * NWORDS;
    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int LVLS = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic            r_sub;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [OPW-1:0]  r_res;
    logic            r_cout;
    logic            r_ovf;
    logic            r_res_valid;
    logic            r_busy;
`ifdef ADDSEQ_ZERO_FLAG_EN
    logic            r_zacc;
    logic            r_zero;
`endif

    logic [WORD_W-1:0] w_aw;
    logic [WORD_W-1:0] w_bw;
    logic [WORD_W-1:0] w_g;
    logic [WORD_W-1:0] w_p;
    logic [WORD_W-1:0] w_gk;
    logic [WORD_W-1:0] w_pk;
    logic [WORD_W-1:0] w_gn;
    logic [WORD_W-1:0] w_pn;
    logic [WORD_W-1:0] w_cin;
    logic [WORD_W-1:0] w_sum;
    logic              w_c;
    logic              w_cmsb;

    assign w_aw = r_a[int'(r_idx)*WORD_W +: WORD_W];
    assign w_bw = r_b[int'(r_idx)*WORD_W +: WORD_W] ^ {WORD_W{r_sub}};

    // Kogge-Stone prefix; carry-in folded into bit 0 generate so the
    // final group-generate at bit i is the carry out of bit i.
    always_comb begin
        w_g  = w_aw & w_bw;
        w_p  = w_aw ^ w_bw;
        w_gk = w_g;
        w_gk[0] = w_g[0] | (w_p[0] & r_carry);
        w_pk = w_p;
        w_gn = w_gk;
        w_pn = w_pk;
        for (int l = 0; l < LVLS; l++) begin
            w_gn = w_gk;
            w_pn = w_pk;
            for (int i = (1 << l); i < WORD_W; i++) begin
                w_gn[i] = w_gk[i] | (w_pk[i] & w_gk[i - (1 << l)]);
                w_pn[i] = w_pk[i] & w_pk[i - (1 << l)];
            end
            w_gk = w_gn;
            w_pk = w_pn;
        end
        w_cin  = {w_gk[WORD_W-2:0], r_carry};
        w_sum  = w_p ^ w_cin;
        w_c    = w_gk[WORD_W-1];
        w_cmsb = w_gk[WORD_W-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ADDSEQ_ZERO_FLAG_EN
            r_zacc      <= 1'b0;
            r_zero      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        r_a     <= bus.a_in;
                        r_b     <= bus.b_in;
                        r_sub   <= bus.op_sub;
                        r_carry <= bus.op_sub;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
`ifdef ADDSEQ_ZERO_FLAG_EN
                        r_zacc  <= 1'b1;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res[int'(r_idx)*WORD_W +: WORD_W] <= w_sum;
                    r_carry <= w_c;
                    r_idx   <= r_idx + IDXW'(1);
`ifdef ADDSEQ_ZERO_FLAG_EN
                    r_zacc  <= r_zacc & ~(|w_sum);
`endif
                    if (r_idx == c_last_idx) begin
                        r_cout      <= w_c;
                        r_ovf       <= w_cmsb ^ w_c;
                        r_res_valid <= 1'b1;
`ifdef ADDSEQ_ZERO_FLAG_EN
                        r_zero      <= r_zacc & ~(|w_sum);
`endif
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Held low while in reset so upstream never sees a ready during abort.
    assign bus.start_ready = (r_state == S_IDLE) && rst_n;
    assign bus.res         = r_res;
    assign bus.cout        = r_cout;
    assign bus.ovf         = r_ovf;
    assign bus.res_valid   = r_res_valid;
    assign bus.busy        = r_busy;
`ifdef ADDSEQ_ZERO_FLAG_EN
    assign bus.zero        = r_zero;
`endif

endmodule
`default_nettype wire
